aes_host_ctrl: RTL and testbench
================================

Name: aes_host_ctrl

Overview:
Word-serial host front-end that sits directly upstream of the AES core. It accepts 32-bit register writes for the key and data block and assembles them into 128-bit staging registers. On command it drives the core's set_key / set_plain_text / set_cipher_text / start_enc / start_dec strobes, waits for done_enc / done_dec, and exposes the result and status for 32-bit read-back.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before a timeout error is flagged (>=16)
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
wr_valid  in  1  host write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_addr  in  4  write word address
wr_data  in  32  write data
rd_en  in  1  read request
rd_addr  in  4  read word address
rd_data  out  32  read data, valid 1 cycle after rd_en
irq  out  1  level interrupt, = done | err_timeout | err_cmd
set_key  out  1  1-cycle strobe to core
key  out  128  staged key
set_plain_text  out  1  1-cycle strobe to core
plain_text_in  out  128  staged data block (encrypt)
set_cipher_text  out  1  1-cycle strobe to core
cipher_text_in  out  128  staged data block (decrypt)
start_enc  out  1  1-cycle strobe to core
start_dec  out  1  1-cycle strobe to core
done_enc  in  1  from core
done_dec  in  1  from core
plain_text_out  in  128  core result/plaintext register
cipher_text_out  in  128  core result/ciphertext register

Behaviour:
- Address map (write): 0-3 key words, 4-7 data words, 8 CMD (bit0 ENC, bit1 DEC), others ignored but accepted. Word n is bits [127-32n -: 32] (word 0 = MSW, FIPS-197 byte order).
- Address map (read): 0-3 cipher_text_out words, 4-7 plain_text_out words, 8 STATUS {28'b0, err_cmd, err_timeout, done, busy}, others return 0.
- plain_text_in and cipher_text_in both carry the same data staging register.
- FSM states: IDLE, LOAD, START, WAIT.
- IDLE: wr_ready=1. A CMD write with exactly one of ENC/DEC set goes to LOAD and latches op. A CMD write of 0 or 3 sets err_cmd and stays in IDLE.
- LOAD (1 cycle): set_key=1, plus set_plain_text=1 for ENC or set_cipher_text=1 for DEC. Then START.
- START (1 cycle): start_enc or start_dec =1 per op. The timeout counter clears. Then WAIT.
- WAIT: exit on done_enc (ENC) or done_dec (DEC): set done, go to IDLE. A done of the wrong type is ignored. If the counter reaches TIMEOUT_CYCLES, set err_timeout and go to IDLE.
- busy=1 and wr_ready=0 in LOAD/START/WAIT. All writes, including writes to staging, stall while busy. Staging cannot change mid-operation.
- Latency: CMD accept at cycle T; set_* at T+1; start_* at T+2; earliest done flag one cycle after core done.
- A STATUS read clears done/err_cmd/err_timeout after the read data is captured. If a set and a clear occur in the same cycle, set wins.
- A new CMD in IDLE does not clear stale flags.
- rd_data is registered and holds its last value when rd_en=0. Reads are allowed in any state.
- Reset (async, any state, mid-operation included): FSM→IDLE; all strobes 0; staging regs, flags, counter, rd_data, irq = 0; wr_ready=1 after reset deasserts.
- All strobes are exactly one cycle wide; none is ever asserted simultaneously with its counterpart op.

Test Plan:
- Write key 000102..0f and data 00112233..eeff via 8 writes, CMD=1 → set_key & set_plain_text pulse at T+1, start_enc at T+2; model done_enc → STATUS=0x2, irq=1, words 0-3 read back cipher_text_out (69c4e0d8...). Second STATUS read returns 0x0.
- CMD=2 with data 69c4e0d86a7b0430d8cdb78070b4c55a → set_cipher_text & start_dec sequence; done_dec → done; words 4-7 return plain_text_out.
- CMD=3, then CMD=0 → no strobes, STATUS=0x8, irq=1.
- Hold done low for 64 cycles in WAIT → STATUS=0x4, FSM back to IDLE, wr_ready=1.
- Write data word during WAIT → wr_ready=0 until done; staging unchanged; a STATUS read during WAIT returns busy=1. Inject done_dec during an ENC op → ignored.
- Assert reset in WAIT → all outputs 0 immediately; next CMD runs a normal sequence.

Source files
------------

// File: rtl/aes_host_ctrl_if.sv
// aes_host_ctrl_if: 32-bit host write/read bus for aes_host_ctrl.
// The master drives requests, and the slave returns ready, read data and irq.
interface aes_host_ctrl_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        irq;

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_en, rd_addr,
    input  wr_ready, rd_data, irq
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_en, rd_addr,
    output wr_ready, rd_data, irq
  );
endinterface

// File: rtl/aes_host_ctrl.sv
// aes_host_ctrl: word-serial host front-end for the AES core.
// Stages key/data, sequences core strobes, reports status.
module aes_host_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic           clk,
  input  logic           reset,
  aes_host_ctrl_if.slave host,
  output logic           set_key,
  output logic [127:0]   key,
  output logic           set_plain_text,
  output logic [127:0]   plain_text_in,
  output logic           set_cipher_text,
  output logic [127:0]   cipher_text_in,
  output logic           start_enc,
  output logic           start_dec,
  input  logic           done_enc,
  input  logic           done_dec,
  input  logic [127:0]   plain_text_out,
  input  logic [127:0]   cipher_text_out
);
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             op_dec_q, op_dec_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_t_q, err_t_d;
  logic             err_c_q, err_c_d;
  logic             set_key_q, set_key_d;
  logic             set_pt_q, set_pt_d;
  logic             set_ct_q, set_ct_d;
  logic             st_enc_q, st_enc_d;
  logic             st_dec_q, st_dec_d;
  logic [31:0]      rd_q, rd_d, rd_word;
  logic             busy, wr_fire, core_done;

  // Word 0 is the most significant word of a 128-bit block.
  function automatic logic [31:0] word_of(
    input logic [127:0] v, input logic [1:0] i);
    unique case (i)
      2'd0:    word_of = v[127:96];
      2'd1:    word_of = v[95:64];
      2'd2:    word_of = v[63:32];
      default: word_of = v[31:0];
    endcase
  endfunction

  function automatic logic [127:0] put_word(
    input logic [127:0] v, input logic [1:0] i,
    input logic [31:0] w);
    logic [127:0] r;
    r = v;
    unique case (i)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  assign busy      = (state_q != IDLE);
  assign wr_fire   = host.wr_valid && !busy;
  assign core_done = op_dec_q ? done_dec : done_enc;

  // Read-back mux: result words, status, zero elsewhere.
  always_comb begin
    rd_word = '0;
    if (host.rd_addr[3:2] == 2'b00)
      rd_word = word_of(cipher_text_out, host.rd_addr[1:0]);
    else if (host.rd_addr[3:2] == 2'b01)
      rd_word = word_of(plain_text_out, host.rd_addr[1:0]);
    else if (host.rd_addr == 4'd8)
      rd_word = {28'b0, err_c_q, err_t_q, done_q, busy};
  end

  // Next-state: host writes, command sequencing, flags, read data.
  always_comb begin
    state_d   = state_q;
    op_dec_d  = op_dec_q;
    key_d     = key_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    err_t_d   = err_t_q;
    err_c_d   = err_c_q;
    set_key_d = 1'b0;
    set_pt_d  = 1'b0;
    set_ct_d  = 1'b0;
    st_enc_d  = 1'b0;
    st_dec_d  = 1'b0;
    rd_d      = rd_q;
    // Status read clears flags; sets below override the clear.
    if (host.rd_en) begin
      rd_d = rd_word;
      if (host.rd_addr == 4'd8) begin
        done_d  = 1'b0;
        err_t_d = 1'b0;
        err_c_d = 1'b0;
      end
    end
    if (wr_fire) begin
      if (host.wr_addr[3:2] == 2'b00)
        key_d = put_word(key_q, host.wr_addr[1:0], host.wr_data);
      else if (host.wr_addr[3:2] == 2'b01)
        data_d = put_word(data_q, host.wr_addr[1:0], host.wr_data);
      else if (host.wr_addr == 4'd8) begin
        unique case (host.wr_data[1:0])
          2'b01, 2'b10: begin
            op_dec_d  = host.wr_data[1];
            state_d   = LOAD;
            set_key_d = 1'b1;
            set_pt_d  = !host.wr_data[1];
            set_ct_d  = host.wr_data[1];
          end
          default: err_c_d = 1'b1;
        endcase
      end
    end
    unique case (state_q)
      IDLE: ;
      LOAD: begin
        state_d  = START;
        st_enc_d = !op_dec_q;
        st_dec_d = op_dec_q;
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (core_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          err_t_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State, staging, flags and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_dec_q  <= 1'b0;
      key_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_t_q   <= 1'b0;
      err_c_q   <= 1'b0;
      set_key_q <= 1'b0;
      set_pt_q  <= 1'b0;
      set_ct_q  <= 1'b0;
      st_enc_q  <= 1'b0;
      st_dec_q  <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_dec_q  <= op_dec_d;
      key_q     <= key_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_t_q   <= err_t_d;
      err_c_q   <= err_c_d;
      set_key_q <= set_key_d;
      set_pt_q  <= set_pt_d;
      set_ct_q  <= set_ct_d;
      st_enc_q  <= st_enc_d;
      st_dec_q  <= st_dec_d;
      rd_q      <= rd_d;
    end
  end

  assign host.wr_ready   = !busy;
  assign host.rd_data    = rd_q;
  assign host.irq        = done_q | err_t_q | err_c_q;
  assign set_key         = set_key_q;
  assign set_plain_text  = set_pt_q;
  assign set_cipher_text = set_ct_q;
  assign start_enc       = st_enc_q;
  assign start_dec       = st_dec_q;
  assign key             = key_q;
  assign plain_text_in   = data_q;
  assign cipher_text_in  = data_q;
endmodule

// File: tb/tb_aes_host_ctrl.sv
// tb_aes_host_ctrl: directed bench for aes_host_ctrl.
// Scenario tasks with hand-computed expectations.
module tb_aes_host_ctrl;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         set_key, set_plain_text, set_cipher_text;
  logic         start_enc, start_dec;
  logic [127:0] key, plain_text_in, cipher_text_in;
  logic         done_enc = 1'b0;
  logic         done_dec = 1'b0;
  logic [127:0] plain_text_out;
  logic [127:0] cipher_text_out;
  int           total = 0;
  int           bad = 0;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_host_ctrl_if hif ();

  aes_host_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .host            (hif),
    .set_key         (set_key),
    .key             (key),
    .set_plain_text  (set_plain_text),
    .plain_text_in   (plain_text_in),
    .set_cipher_text (set_cipher_text),
    .cipher_text_in  (cipher_text_in),
    .start_enc       (start_enc),
    .start_dec       (start_dec),
    .done_enc        (done_enc),
    .done_dec        (done_dec),
    .plain_text_out  (plain_text_out),
    .cipher_text_out (cipher_text_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    hif.wr_valid = 1'b1;
    hif.wr_addr  = a;
    hif.wr_data  = d;
    step();
    hif.wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    hif.rd_en   = 1'b1;
    hif.rd_addr = a;
    step();
    hif.rd_en = 1'b0;
    d = hif.rd_data;
  endtask

  task automatic pulse_enc();
    done_enc = 1'b1;
    step();
    done_enc = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    total++;
    if ({set_key, set_plain_text, set_cipher_text, start_enc,
         start_dec, hif.irq} !== 6'b0) begin
      bad++;
      $display("FAIL rst_strobes got=%b%b%b%b%b irq=%b exp=0",
        set_key, set_plain_text, set_cipher_text, start_enc,
        start_dec, hif.irq);
    end
    total++;
    if (key !== '0 || plain_text_in !== '0 || hif.rd_data !== '0) begin
      bad++;
      $display("FAIL rst_regs key=%h data=%h rd=%h exp=0",
        key, plain_text_in, hif.rd_data);
    end
    step();
    reset = 1'b0;
    #1;
    total++;
    if (hif.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_wr_ready got=%b exp=1", hif.wr_ready);
    end
    rd(4'd8, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL rst_status got=%h exp=0", d);
    end
  endtask

  task automatic test_enc();
    logic [31:0] d;
    logic [127:0] t;
    for (int i = 0; i < 4; i++) begin
      t = KEY;
      wr(4'(i), t[127-32*i -: 32]);
    end
    for (int i = 0; i < 4; i++) begin
      t = PT;
      wr(4'(4+i), t[127-32*i -: 32]);
    end
    total++;
    if (key !== KEY || plain_text_in !== PT || cipher_text_in !== PT) begin
      bad++;
      $display("FAIL enc_staging key=%h pt=%h ct=%h exp=%h/%h",
        key, plain_text_in, cipher_text_in, KEY, PT);
    end
    wr(4'd8, 32'h1);
    total++;
    if ({set_key, set_plain_text, set_cipher_text, start_enc} !== 4'b1100) begin
      bad++;
      $display("FAIL enc_load got=%b%b%b%b exp=1100",
        set_key, set_plain_text, set_cipher_text, start_enc);
    end
    step();
    total++;
    if ({set_key, set_plain_text, start_enc, start_dec} !== 4'b0010) begin
      bad++;
      $display("FAIL enc_start got=%b%b%b%b exp=0010",
        set_key, set_plain_text, start_enc, start_dec);
    end
    step();
    total++;
    if (start_enc !== 1'b0 || hif.wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL enc_wait start=%b ready=%b exp=0/0",
        start_enc, hif.wr_ready);
    end
    pulse_enc();
    total++;
    if (hif.irq !== 1'b1 || hif.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL enc_done irq=%b ready=%b exp=1/1",
        hif.irq, hif.wr_ready);
    end
    rd(4'd8, d);
    total++;
    if (d !== 32'h2) begin
      bad++;
      $display("FAIL enc_status got=%h exp=2", d);
    end
    total++;
    if (hif.irq !== 1'b0) begin
      bad++;
      $display("FAIL enc_irq_clr got=%b exp=0", hif.irq);
    end
    for (int i = 0; i < 4; i++) begin
      rd(4'(i), d);
      t = CT;
      total++;
      if (d !== t[127-32*i -: 32]) begin
        bad++;
        $display("FAIL enc_word%0d got=%h exp=%h", i, d, t[127-32*i -: 32]);
      end
    end
    rd(4'd8, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL enc_status2 got=%h exp=0", d);
    end
  endtask

  task automatic test_dec();
    logic [31:0] d;
    logic [127:0] t;
    for (int i = 0; i < 4; i++) begin
      t = CT;
      wr(4'(4+i), t[127-32*i -: 32]);
    end
    wr(4'd8, 32'h2);
    total++;
    if ({set_key, set_plain_text, set_cipher_text, start_dec} !== 4'b1010
        || cipher_text_in !== CT) begin
      bad++;
      $display("FAIL dec_load got=%b%b%b%b ct=%h exp=1010/%h",
        set_key, set_plain_text, set_cipher_text, start_dec,
        cipher_text_in, CT);
    end
    step();
    total++;
    if ({set_cipher_text, start_enc, start_dec} !== 3'b001) begin
      bad++;
      $display("FAIL dec_start got=%b%b%b exp=001",
        set_cipher_text, start_enc, start_dec);
    end
    step();
    done_dec = 1'b1;
    step();
    done_dec = 1'b0;
    rd(4'd8, d);
    total++;
    if (d !== 32'h2) begin
      bad++;
      $display("FAIL dec_status got=%h exp=2", d);
    end
    for (int i = 0; i < 4; i++) begin
      rd(4'(4+i), d);
      t = PT;
      total++;
      if (d !== t[127-32*i -: 32]) begin
        bad++;
        $display("FAIL dec_word%0d got=%h exp=%h", i, d, t[127-32*i -: 32]);
      end
    end
  endtask

  task automatic test_bad_cmd();
    logic [31:0] d;
    wr(4'd8, 32'h3);
    total++;
    if ({set_key, set_plain_text, set_cipher_text} !== 3'b000
        || hif.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL bad3 strobes=%b%b%b ready=%b exp=000/1",
        set_key, set_plain_text, set_cipher_text, hif.wr_ready);
    end
    wr(4'd8, 32'h0);
    step();
    total++;
    if (start_enc !== 1'b0 || start_dec !== 1'b0 || hif.irq !== 1'b1) begin
      bad++;
      $display("FAIL bad0 start=%b%b irq=%b exp=00/1",
        start_enc, start_dec, hif.irq);
    end
    rd(4'd8, d);
    total++;
    if (d !== 32'h8) begin
      bad++;
      $display("FAIL bad_status got=%h exp=8", d);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    wr(4'd8, 32'h1);
    repeat (60) step();
    total++;
    if (hif.wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL to_early ready=%b exp=0", hif.wr_ready);
    end
    repeat (20) step();
    total++;
    if (hif.wr_ready !== 1'b1 || hif.irq !== 1'b1) begin
      bad++;
      $display("FAIL to_idle ready=%b irq=%b exp=1/1",
        hif.wr_ready, hif.irq);
    end
    rd(4'd8, d);
    total++;
    if (d !== 32'h4) begin
      bad++;
      $display("FAIL to_status got=%h exp=4", d);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    wr(4'd8, 32'h1);
    step();
    step();
    hif.wr_valid = 1'b1;
    hif.wr_addr  = 4'd4;
    hif.wr_data  = 32'hdeadbeef;
    done_dec = 1'b1;
    step();
    done_dec = 1'b0;
    total++;
    if (hif.wr_ready !== 1'b0 || hif.irq !== 1'b0) begin
      bad++;
      $display("FAIL stall_wrong_done ready=%b irq=%b exp=0/0",
        hif.wr_ready, hif.irq);
    end
    rd(4'd8, d);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL stall_status got=%h exp=1", d);
    end
    hif.wr_valid = 1'b0;
    total++;
    if (plain_text_in !== CT) begin
      bad++;
      $display("FAIL stall_staging got=%h exp=%h", plain_text_in, CT);
    end
    pulse_enc();
    total++;
    if (hif.wr_ready !== 1'b1 || plain_text_in !== CT) begin
      bad++;
      $display("FAIL stall_end ready=%b pt=%h exp=1/%h",
        hif.wr_ready, plain_text_in, CT);
    end
    rd(4'd8, d);
    total++;
    if (d !== 32'h2) begin
      bad++;
      $display("FAIL stall_done got=%h exp=2", d);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    wr(4'd8, 32'h0);
    wr(4'd8, 32'h1);
    rd(4'd0, d);
    step();
    total++;
    if (hif.irq !== 1'b1 || hif.rd_data !== 32'h69c4e0d8) begin
      bad++;
      $display("FAIL mr_pre irq=%b rd=%h exp=1/69c4e0d8",
        hif.irq, hif.rd_data);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({set_key, start_enc, start_dec, hif.irq} !== 4'b0
        || key !== '0 || plain_text_in !== '0 || hif.rd_data !== '0) begin
      bad++;
      $display("FAIL mr_async str=%b%b%b irq=%b key=%h rd=%h exp=0",
        set_key, start_enc, start_dec, hif.irq, key, hif.rd_data);
    end
    step();
    reset = 1'b0;
    #1;
    total++;
    if (hif.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL mr_ready got=%b exp=1", hif.wr_ready);
    end
    wr(4'd8, 32'h1);
    total++;
    if ({set_key, set_plain_text} !== 2'b11) begin
      bad++;
      $display("FAIL mr_load got=%b%b exp=11", set_key, set_plain_text);
    end
    step();
    total++;
    if (start_enc !== 1'b1) begin
      bad++;
      $display("FAIL mr_start got=%b exp=1", start_enc);
    end
    step();
    pulse_enc();
    rd(4'd8, d);
    total++;
    if (d !== 32'h2) begin
      bad++;
      $display("FAIL mr_status got=%h exp=2", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    hif.wr_valid = 1'b0;
    hif.wr_addr  = '0;
    hif.wr_data  = '0;
    hif.rd_en    = 1'b0;
    hif.rd_addr  = '0;
    cipher_text_out = CT;
    plain_text_out  = PT;
    test_reset();
    test_enc();
    test_dec();
    test_bad_cmd();
    test_timeout();
    test_stall();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
